// File: rtl/encoder_capture_if.sv
// Host register-write bus and byte stream toward the UART transmitter.
// The capture block is the slave on both: it takes writes and sources bytes.
interface encoder_capture_if;
    logic        m_wr;
    logic [7:0]  m_addr;
    logic [15:0] m_wrdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave  (input  m_wr, m_addr, m_wrdata, tx_ready,
                    output tx_data, tx_valid);
    modport master (output m_wr, m_addr, m_wrdata, tx_ready,
                    input  tx_data, tx_valid);
endinterface

// File: rtl/encoder_capture.sv
// Multi-channel 4x quadrature decoder with glitch filter, wrapping counters and
// a checksummed snapshot frame streamed out over valid/ready.
module encoder_capture #(
    parameter int         CH        = 2,
    parameter int         CNT_W     = 32,
    parameter int         FILT      = 3,
    parameter logic [7:0] ADDR_CTRL = 8'h20,
    parameter logic [7:0] ADDR_DIR  = 8'h21,
    parameter logic [7:0] ADDR_CLR  = 8'h22,
    parameter logic [7:0] ADDR_PER  = 8'h23,
    parameter logic [7:0] ADDR_SNAP = 8'h24
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    encoder_capture_if.slave      bus,
    input  logic [CH-1:0]         enc_a_i,
    input  logic [CH-1:0]         enc_b_i,
    output logic [CH*CNT_W-1:0]   pos_flat_o,
    output logic [CH-1:0]         err_o,
    output logic                  busy_o
);
    localparam int               NB     = CNT_W / 8;
    localparam int               LEN    = 3 + CH * NB;
    localparam int               IDX_W  = $clog2(LEN);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(LEN - 1);
    localparam logic [3:0]       FILT_L = 4'(FILT);

    genvar gi;

    // ---------------- host registers ----------------
    logic          wr_ctrl, wr_dir, wr_clr, wr_per, wr_snap;
    logic          en_q, auto_q;
    logic [CH-1:0] dir_q;
    logic [15:0]   per_q, timer_q;
    logic          timer_run, timer_hit, trigger;

    assign wr_ctrl = bus.m_wr && (bus.m_addr == ADDR_CTRL);
    assign wr_dir  = bus.m_wr && (bus.m_addr == ADDR_DIR);
    assign wr_clr  = bus.m_wr && (bus.m_addr == ADDR_CLR);
    assign wr_per  = bus.m_wr && (bus.m_addr == ADDR_PER);
    assign wr_snap = bus.m_wr && (bus.m_addr == ADDR_SNAP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q   <= 1'b0;
            auto_q <= 1'b0;
            dir_q  <= '0;
            per_q  <= '0;
        end else begin
            if (wr_ctrl) begin
                en_q   <= bus.m_wrdata[0];
                auto_q <= bus.m_wrdata[1];
            end
            if (wr_dir) dir_q <= bus.m_wrdata[CH-1:0];
            if (wr_per) per_q <= bus.m_wrdata;
        end
    end

    // Period timer runs 0..PER-1; any CTRL/PER write restarts the count.
    assign timer_run = en_q && auto_q && (per_q != 16'd0);
    assign timer_hit = timer_run && (timer_q == per_q - 16'd1);
    assign trigger   = wr_snap || timer_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else if (wr_ctrl || wr_per || !timer_run || timer_hit) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 16'd1;
        end
    end

    // ---------------- per-channel input path and counter ----------------
    for (gi = 0; gi < CH; gi++) begin : g_ch
        logic [1:0]       s1_q, s2_q, samp_q, filt_q, last_q;
        logic [3:0]       run_q, run_d;
        logic [CNT_W-1:0] cnt_q;
        logic             err_q;
        logic [1:0]       cur_idx, prev_idx, diff;
        logic             fwd, rev, bad, up, dn, clr;

        // run_d counts consecutive identical synchronised samples, saturating at FILT.
        always_comb begin
            run_d = 4'd1;
            if (s2_q == samp_q) begin
                run_d = (run_q == FILT_L) ? run_q : run_q + 4'd1;
            end
        end

        // {A,B} 00,10,11,01 maps onto position index {B, A^B} = 0,1,2,3.
        assign cur_idx  = {filt_q[0], filt_q[1] ^ filt_q[0]};
        assign prev_idx = {last_q[0], last_q[1] ^ last_q[0]};
        assign diff     = cur_idx - prev_idx;
        assign fwd      = (diff == 2'd1);
        assign rev      = (diff == 2'd3);
        assign bad      = (diff == 2'd2);
        assign up       = dir_q[gi] ? rev : fwd;
        assign dn       = dir_q[gi] ? fwd : rev;
        assign clr      = wr_clr && bus.m_wrdata[gi];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s1_q   <= '0;
                s2_q   <= '0;
                samp_q <= '0;
                run_q  <= '0;
                filt_q <= '0;
                last_q <= '0;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end else begin
                s1_q   <= {enc_a_i[gi], enc_b_i[gi]};
                s2_q   <= s1_q;
                samp_q <= s2_q;
                run_q  <= run_d;
                if (run_d == FILT_L) filt_q <= s2_q;
                last_q <= filt_q;
                if (clr) begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end else begin
                    if (en_q && up)      cnt_q <= cnt_q + CNT_W'(1);
                    else if (en_q && dn) cnt_q <= cnt_q - CNT_W'(1);
                    if (bad) err_q <= 1'b1;
                end
            end
        end

        assign pos_flat_o[gi*CNT_W +: CNT_W] = cnt_q;
        assign err_o[gi]                     = err_q;
    end

    // ---------------- snapshot frame ----------------
    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         tx_data_q, byte_d, csum_q, status_q, status_d;
    logic               tx_valid_q, busy_q, ovr_q;
    logic [CH*CNT_W-1:0] shadow_q;
    logic [7:0]         fb [2**IDX_W];

    // Frame bytes by position; slot 0 (sync) and the checksum slot are handled in the mux.
    for (gi = 0; gi < 2**IDX_W; gi++) begin : g_fb
        if (gi == 1) begin : g_status
            assign fb[gi] = status_q;
        end else if (gi >= 2 && gi <= LEN - 2) begin : g_cnt
            assign fb[gi] = shadow_q[((gi-2)/NB)*CNT_W + (NB-1-((gi-2)%NB))*8 +: 8];
        end else begin : g_pad
            assign fb[gi] = 8'h00;
        end
    end

    always_comb begin
        status_d        = 8'h00;
        status_d[CH-1:0] = err_o;
        status_d[7]     = ovr_q;
        idx_d           = idx_q + IDX_W'(1);
        byte_d          = (idx_d == LAST) ? (csum_q ^ tx_data_q) : fb[idx_d];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            csum_q     <= 8'h00;
            ovr_q      <= 1'b0;
            status_q   <= 8'h00;
            shadow_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        shadow_q   <= pos_flat_o;
                        status_q   <= status_d;
                        ovr_q      <= 1'b0;
                        idx_q      <= '0;
                        tx_data_q  <= 8'hA5;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        csum_q     <= 8'h00;
                        state_q    <= S_SEND;
                    end
                end
                S_SEND: begin
                    // A trigger arriving while busy is dropped but remembered.
                    if (trigger) ovr_q <= 1'b1;
                    if (tx_valid_q && bus.tx_ready) begin
                        csum_q <= csum_q ^ tx_data_q;
                        if (idx_q == LAST) begin
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= byte_d;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_encoder_capture.sv
// Bench for encoder_capture: vector table, corner sequences, random steps vs. a position model.
module tb_encoder_capture;
    localparam int CH = 2, CNT_W = 16, FILT = 3, NB = CNT_W / 8;
    localparam int LEN = 3 + CH * NB;
    localparam int SETTLE = FILT + 5;
    localparam logic [7:0] A_CTRL = 8'h20, A_DIR = 8'h21, A_CLR = 8'h22,
                           A_PER = 8'h23, A_SNAP = 8'h24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CH-1:0] enc_a = '0, enc_b = '0;
    logic [CH*CNT_W-1:0] pos_flat;
    logic [CH-1:0] err;
    logic busy;

    encoder_capture_if bus();

    encoder_capture #(.CH(CH), .CNT_W(CNT_W), .FILT(FILT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus),
        .enc_a_i(enc_a), .enc_b_i(enc_b),
        .pos_flat_o(pos_flat), .err_o(err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int ph [CH];
    int mpos [CH];
    logic [CH-1:0] mdir;
    logic [7:0] rx_q [$];
    logic [7:0] expf [LEN];
    logic [7:0] lit_frame [LEN] = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'hFF, 8'hFF, 8'hB5};

    typedef struct {
        int         ch;
        int         nsteps;
        logic       dir0;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;
    vec_t vt [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic [15:0] pos(input int c);
        return pos_flat[c*CNT_W +: CNT_W];
    endfunction

    task automatic set_pins(input int c);
        enc_a[c] = (ph[c] == 1 || ph[c] == 2);
        enc_b[c] = (ph[c] >= 2);
    endtask

    task automatic step(input int c, input int s);
        @(posedge clk); #1;
        ph[c] = (ph[c] + s + 4) % 4;
        set_pins(c);
        repeat (SETTLE) @(posedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        bus.m_wr = 1'b1; bus.m_addr = a; bus.m_wrdata = d;
        @(posedge clk); #1;
        bus.m_wr = 1'b0;
    endtask

    // Expected frame from the position model: sync, status, MSB-first counts, XOR.
    task automatic exp_frame(input logic [7:0] st);
        logic [7:0] x;
        int k;
        expf[0] = 8'hA5;
        expf[1] = st;
        k = 2;
        for (int c = 0; c < CH; c++)
            for (int b = NB - 1; b >= 0; b--) begin
                expf[k] = 8'((mpos[c] >> (8 * b)) & 'hFF);
                k++;
            end
        x = 8'h00;
        for (int i = 0; i < LEN - 1; i++) x = x ^ expf[i];
        expf[LEN-1] = x;
    endtask

    task automatic recv(input bit toggle, input string tag);
        bit held;
        logic [7:0] hd;
        rx_q.delete();
        held = 1'b0;
        hd = 8'h00;
        for (int ci = 0; ci < 200 && rx_q.size() < LEN; ci++) begin
            @(posedge clk); #1;
            bus.tx_ready = toggle ? ((ci % 2) == 0) : 1'b1;
            @(negedge clk);
            if (bus.tx_valid) begin
                if (held) check({tag, " hold"}, 32'(bus.tx_data), 32'(hd));
                if (bus.tx_ready) begin
                    rx_q.push_back(bus.tx_data);
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = bus.tx_data;
                end
            end
        end
        if (rx_q.size() < LEN) begin
            checks++; errors++;
            $display("FAIL %s timeout: got %0d bytes need %0d", tag, rx_q.size(), LEN);
        end
        @(posedge clk); #1;
        bus.tx_ready = 1'b0;
        @(negedge clk);
        check({tag, " busy end"}, 32'(busy), 32'h0);
        check({tag, " valid end"}, 32'(bus.tx_valid), 32'h0);
    endtask

    task automatic cmp_frame(input string tag);
        for (int i = 0; i < LEN && i < rx_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), 32'(rx_q[i]), 32'(expf[i]));
    endtask

    task automatic wait_start(output int t);
        logic prev;
        prev = busy;
        t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy && !prev) begin
                t = cyc;
                break;
            end
            prev = busy;
        end
        if (t < 0) begin
            checks++; errors++;
            $display("FAIL auto start timeout: no frame start within 300 cycles");
        end
    endtask

    initial begin
        int t1, t2, t3, rises;
        logic prev_b;
        bus.m_wr = 1'b0; bus.m_addr = 8'h00; bus.m_wrdata = 16'h0000; bus.tx_ready = 1'b0;
        for (int c = 0; c < CH; c++) begin ph[c] = 0; mpos[c] = 0; end

        vt[0] = '{0, 16, 1'b0, 16'h0010, 16'h0000};
        vt[1] = '{0, -5, 1'b0, 16'h000B, 16'h0000};
        vt[2] = '{0,  2, 1'b1, 16'h0009, 16'h0000};
        vt[3] = '{0, -1, 1'b0, 16'hFFFF, 16'h0000};
        vt[4] = '{0,  1, 1'b0, 16'h0000, 16'h0000};

        // Reset with inputs toggling.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            enc_a = CH'($urandom); enc_b = CH'($urandom);
        end
        @(negedge clk);
        check("reset pos", pos_flat, 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset valid", 32'(bus.tx_valid), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset data", 32'(bus.tx_data), 32'h0);
        enc_a = '0; enc_b = '0;
        repeat (SETTLE) @(posedge clk);
        #1 rst_n = 1'b1;

        // EN=0: movement is tracked but not counted, no step on enable.
        for (int i = 0; i < 3; i++) step(0, 1);
        @(negedge clk);
        check("en0 no count", 32'(pos(0)), 32'h0);
        wr(A_CTRL, 16'h0001);
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
        check("enable no spurious", 32'(pos(0)), 32'h0);

        // Pin-to-counter latency is FILT+3 edges.
        @(posedge clk); #1;
        ph[0] = (ph[0] + 1) % 4; set_pins(0);
        repeat (FILT + 2) @(posedge clk);
        @(negedge clk);
        check("latency early", 32'(pos(0)), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("latency on time", 32'(pos(0)), 32'h1);
        step(0, -1);

        for (int v = 0; v < 3; v++) begin
            wr(A_DIR, 16'(vt[v].dir0));
            for (int s = 0; s < (vt[v].nsteps < 0 ? -vt[v].nsteps : vt[v].nsteps); s++)
                step(vt[v].ch, vt[v].nsteps < 0 ? -1 : 1);
            @(negedge clk);
            check($sformatf("vec%0d pos0", v), 32'(pos(0)), 32'(vt[v].exp0));
            check($sformatf("vec%0d pos1", v), 32'(pos(1)), 32'(vt[v].exp1));
        end

        // Two-cycle glitch on A is rejected.
        @(posedge clk); #1 enc_a[0] = ~enc_a[0];
        @(posedge clk); @(posedge clk); #1 enc_a[0] = ~enc_a[0];
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
        check("glitch pos0", 32'(pos(0)), 32'h9);
        check("glitch err0", 32'(err[0]), 32'h0);

        // Both phases flipping at once is illegal.
        @(posedge clk); #1;
        ph[0] = (ph[0] + 2) % 4; set_pins(0);
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
        check("illegal pos0", 32'(pos(0)), 32'h9);
        check("illegal err0", 32'(err[0]), 32'h1);

        wr(A_CLR, 16'h0001);
        @(negedge clk);
        check("clr pos0", 32'(pos(0)), 32'h0);
        check("clr err0", 32'(err[0]), 32'h0);

        for (int v = 3; v < 5; v++) begin
            wr(A_DIR, 16'(vt[v].dir0));
            for (int s = 0; s < (vt[v].nsteps < 0 ? -vt[v].nsteps : vt[v].nsteps); s++)
                step(vt[v].ch, vt[v].nsteps < 0 ? -1 : 1);
            @(negedge clk);
            check($sformatf("vec%0d pos0", v), 32'(pos(0)), 32'(vt[v].exp0));
            check($sformatf("vec%0d pos1", v), 32'(pos(1)), 32'(vt[v].exp1));
        end

        // Snapshot frame with throttled ready.
        for (int i = 0; i < 16; i++) step(0, 1);
        step(1, -1);
        wr(A_SNAP, 16'h0000);
        @(negedge clk);
        check("snap valid", 32'(bus.tx_valid), 32'h1);
        check("snap first", 32'(bus.tx_data), 32'hA5);
        check("snap busy", 32'(busy), 32'h1);
        recv(1'b1, "frame1");
        for (int i = 0; i < LEN; i++) expf[i] = lit_frame[i];
        cmp_frame("frame1");

        // Overrun reporting.
        mpos[0] = 16'h0010; mpos[1] = 16'hFFFF;
        wr(A_SNAP, 16'h0000);
        wr(A_SNAP, 16'h0000);
        recv(1'b0, "ovr_a");
        exp_frame(8'h00); cmp_frame("ovr_a");
        wr(A_SNAP, 16'h0000);
        recv(1'b0, "ovr_b");
        exp_frame(8'h80); cmp_frame("ovr_b");
        wr(A_SNAP, 16'h0000);
        recv(1'b1, "ovr_c");
        exp_frame(8'h00); cmp_frame("ovr_c");

        // Periodic trigger.
        bus.tx_ready = 1'b1;
        wr(A_PER, 16'd100);
        wr(A_CTRL, 16'h0003);
        wait_start(t1);
        wait_start(t2);
        wait_start(t3);
        check("auto period 1", 32'(t2 - t1), 32'd100);
        check("auto period 2", 32'(t3 - t2), 32'd100);
        wr(A_CTRL, 16'h0001);
        repeat (20) @(posedge clk);
        rises = 0;
        prev_b = busy;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (busy && !prev_b) rises++;
            prev_b = busy;
        end
        check("auto off", 32'(rises), 32'h0);
        @(posedge clk); #1 bus.tx_ready = 1'b0;

        // Random steps and direction/clear changes against the model.
        wr(A_CLR, 16'h0003);
        mpos[0] = 0; mpos[1] = 0; mdir = '0;
        wr(A_DIR, 16'h0000);
        for (int n = 0; n < 40; n++) begin
            int c, s, d;
            logic [CH-1:0] m;
            if ($urandom_range(0, 7) == 0) begin
                mdir = CH'($urandom);
                wr(A_DIR, 16'(mdir));
            end
            if ($urandom_range(0, 11) == 0) begin
                m = CH'($urandom);
                wr(A_CLR, 16'(m));
                for (int k = 0; k < CH; k++) if (m[k]) mpos[k] = 0;
            end
            c = $urandom_range(0, CH - 1);
            s = ($urandom_range(0, 1) == 1) ? 1 : -1;
            step(c, s);
            d = mdir[c] ? -s : s;
            mpos[c] = (mpos[c] + d) & 'hFFFF;
            @(negedge clk);
            check($sformatf("rand%0d pos0", n), 32'(pos(0)), 32'(mpos[0]));
            check($sformatf("rand%0d pos1", n), 32'(pos(1)), 32'(mpos[1]));
        end
        wr(A_SNAP, 16'h0000);
        recv(1'b1, "rand frame");
        exp_frame(8'h00); cmp_frame("rand frame");

        // Asynchronous reset during a frame aborts it at once.
        wr(A_SNAP, 16'h0000);
        @(negedge clk);
        check("abort busy before", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("abort valid", 32'(bus.tx_valid), 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        check("abort pos", pos_flat, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort idle", 32'(bus.tx_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
